// File: rtl/pipe_sub32_pkg.sv
// pipe_sub32_pkg: shared widths and the slice result payload for the pipelined subtractor.
// No ports; imported by pipe_sub32 and sub_slice8.
package pipe_sub32_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SLICE_W = 8;
  localparam int unsigned STAGES  = WORD_W / SLICE_W;

  // Result of one byte slice as produced by sub_slice8
  typedef struct packed {
    logic [SLICE_W-1:0] sum;
    logic               carry;
    logic               byteZero;
  } slice_res_t;

endpackage

// File: rtl/sub_slice8.sv
// sub_slice8: combinational byte slice computing a + ~b + cin.
// Ports:
//   a, b   : operand bytes
//   cin    : carry in (1 into the least significant slice)
//   res_c  : packed sum byte, carry-out and byte==0 flag
module sub_slice8
  import pipe_sub32_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output slice_res_t         res_c
);

  localparam int unsigned SUM_W = SLICE_W + 1;

  logic [SUM_W-1:0] total;

  // Extra top bit captures the carry-out of the byte add
  assign total = {1'b0, a} + {1'b0, ~b} + SUM_W'(cin);

  assign res_c.sum      = total[SLICE_W-1:0];
  assign res_c.carry    = total[SLICE_W];
  assign res_c.byteZero = (total[SLICE_W-1:0] == '0);

endmodule

// File: rtl/pipe_sub32.sv
// pipe_sub32: 4-stage pipelined 32-bit subtractor, one byte per stage, valid/ready on both sides.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake for the operand pair a, b
//   out_valid / out_ready: output handshake for diff and flags
//   diff                 : a - b modulo 2^32
//   borrow, zero, neg, ovf: unsigned borrow, diff==0, diff[31], signed overflow
module pipe_sub32
  import pipe_sub32_pkg::*;
#(
  parameter int unsigned SLICE_W = 8,
  parameter int unsigned STAGES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] diff,
  output logic              borrow,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  localparam int unsigned SW = SLICE_W;

  logic              adv;
  logic [STAGES-1:0] vld;

  // Stage 0: low diff byte plus skewed upper operand bytes
  logic [SW-1:0]          s0Diff;
  logic                   s0Carry, s0Zero;
  logic [WORD_W-SW-1:0]   s0A, s0B;
  // Stage 1
  logic [2*SW-1:0]        s1Diff;
  logic                   s1Carry, s1Zero;
  logic [WORD_W-2*SW-1:0] s1A, s1B;
  // Stage 2 (top byte still holds a[31], b[31] for overflow)
  logic [3*SW-1:0]        s2Diff;
  logic                   s2Carry, s2Zero;
  logic [SW-1:0]          s2A, s2B;
  // Stage 3: output registers
  logic [WORD_W-1:0]      s3Diff;
  logic                   s3Borrow, s3Zero, s3Neg, s3Ovf;

  slice_res_t r0_c, r1_c, r2_c, r3_c;

  sub_slice8 uSlice0 (.a(a[SW-1:0]), .b(b[SW-1:0]), .cin(1'b1),    .res_c(r0_c));
  sub_slice8 uSlice1 (.a(s0A[SW-1:0]), .b(s0B[SW-1:0]), .cin(s0Carry), .res_c(r1_c));
  sub_slice8 uSlice2 (.a(s1A[SW-1:0]), .b(s1B[SW-1:0]), .cin(s1Carry), .res_c(r2_c));
  sub_slice8 uSlice3 (.a(s2A),          .b(s2B),          .cin(s2Carry), .res_c(r3_c));

  // Whole pipe moves together unless the output is held by the consumer
  assign adv      = !vld[STAGES-1] | out_ready;
  assign in_ready = adv;

  // Stage data loads only behind a valid entry so bubbles leave data untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      vld      <= '0;
      s0Diff   <= '0; s0Carry <= 1'b0; s0Zero <= 1'b0; s0A <= '0; s0B <= '0;
      s1Diff   <= '0; s1Carry <= 1'b0; s1Zero <= 1'b0; s1A <= '0; s1B <= '0;
      s2Diff   <= '0; s2Carry <= 1'b0; s2Zero <= 1'b0; s2A <= '0; s2B <= '0;
      s3Diff   <= '0;
      s3Borrow <= 1'b0; s3Zero <= 1'b0; s3Neg <= 1'b0; s3Ovf <= 1'b0;
    end else if (adv) begin
      vld <= {vld[STAGES-2:0], in_valid};
      if (in_valid) begin
        s0Diff  <= r0_c.sum;
        s0Carry <= r0_c.carry;
        s0Zero  <= r0_c.byteZero;
        s0A     <= a[WORD_W-1:SW];
        s0B     <= b[WORD_W-1:SW];
      end
      if (vld[0]) begin
        s1Diff  <= {r1_c.sum, s0Diff};
        s1Carry <= r1_c.carry;
        s1Zero  <= s0Zero & r1_c.byteZero;
        s1A     <= s0A[WORD_W-SW-1:SW];
        s1B     <= s0B[WORD_W-SW-1:SW];
      end
      if (vld[1]) begin
        s2Diff  <= {r2_c.sum, s1Diff};
        s2Carry <= r2_c.carry;
        s2Zero  <= s1Zero & r2_c.byteZero;
        s2A     <= s1A[WORD_W-2*SW-1:SW];
        s2B     <= s1B[WORD_W-2*SW-1:SW];
      end
      if (vld[2]) begin
        s3Diff   <= {r3_c.sum, s2Diff};
        s3Borrow <= !r3_c.carry;
        s3Zero   <= s2Zero & r3_c.byteZero;
        s3Neg    <= r3_c.sum[SW-1];
        s3Ovf    <= (s2A[SW-1] != s2B[SW-1]) & (r3_c.sum[SW-1] != s2A[SW-1]);
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign diff      = s3Diff;
  assign borrow    = s3Borrow;
  assign zero      = s3Zero;
  assign neg       = s3Neg;
  assign ovf       = s3Ovf;

endmodule

// File: tb/tb_pipe_sub32.sv
// tb_pipe_sub32: self-checking bench for pipe_sub32 against an arithmetic reference model.
module tb_pipe_sub32;

  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;
  logic        neg;
  logic        ovf;
  res_t        obs;

  int checks = 0;
  int errors = 0;

  pipe_sub32 #(.SLICE_W(8), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zero(zero), .neg(neg), .ovf(ovf)
  );

  assign obs = {diff, borrow, zero, neg, ovf};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 32-bit and 64-bit signed arithmetic
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t   r;
    longint sd;
    longint lim;
    lim      = 64'sd2147483647;
    r.diff   = x - y;
    r.borrow = (x < y);
    r.zero   = (r.diff == 32'd0);
    r.neg    = r.diff[31];
    sd       = longint'($signed(x)) - longint'($signed(y));
    r.ovf    = (sd > lim) || (sd < -lim - 64'sd1);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || obs !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_state: out_valid=%b obs=%h in_ready=%b, want 0/0/1", out_valid, obs, in_ready);
    rst = 1'b0; in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL reset_ignores_in_valid: out_valid=%b obs=%h, want 0/0", out_valid, obs);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    res_t        exp;
    int          lat;
    va = '{32'd5, 32'd0, 32'h80000000, 32'h7FFFFFFF, 32'h12345678, 32'h000000FF};
    vb = '{32'd3, 32'd1, 32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h000001FF};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i];
      exp = model(va[i], vb[i]);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat);
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, obs, exp);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_single_output[%0d]: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t        q[$];
    res_t        exp;
    res_t        prevObs;
    logic [31:0] av [8];
    logic [31:0] bv [8];
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    int          idx;
    logic        prevStall = 1'b0;
    prevObs = '0;
    for (int i = 0; i < 8; i++) begin av[i] = $urandom; bv[i] = $urandom; end
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (sent < 8);
      idx       = (sent < 8) ? sent : 0;
      a = av[idx]; b = bv[idx];
      #1;
      checks++;
      if (in_ready !== (!out_valid | out_ready)) begin
        errors++;
        $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, in_ready, !out_valid | out_ready);
      end
      if (cyc >= 5 && cyc <= 7) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall cyc%0d: in_ready=%b out_valid=%b want 0/1", cyc, in_ready, out_valid);
        end
      end
      if (prevStall) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== prevObs) begin
          errors++;
          $display("FAIL b2b_hold cyc%0d: got %h want %h", cyc, obs, prevObs);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_output cyc%0d: got %h want none", cyc, obs);
        end else begin
          exp = q.pop_front();
          if (obs !== exp) begin
            errors++;
            $display("FAIL b2b_result %0d: got %h want %h", got, obs, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(a, b));
        sent++;
      end
      prevStall = (out_valid === 1'b1) && !out_ready;
      prevObs   = obs;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got != 8 || sent != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d want 8/8/0", sent, got, q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t exp;
    res_t prevObs;
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    logic prevStall = 1'b0;
    prevObs = '0;
    while (got < 100 && cyc < 2000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      #1;
      checks++;
      if (in_ready !== (!out_valid | out_ready)) begin
        errors++;
        $display("FAIL rnd_in_ready cyc%0d: got %b want %b", cyc, in_ready, !out_valid | out_ready);
      end
      if (prevStall) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== prevObs) begin
          errors++;
          $display("FAIL rnd_hold cyc%0d: got %h want %h", cyc, obs, prevObs);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_output cyc%0d: got %h want none", cyc, obs);
        end else begin
          exp = q.pop_front();
          if (obs !== exp) begin
            errors++;
            $display("FAIL rnd_result %0d: got %h want %h", got, obs, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(a, b));
        sent++;
      end
      prevStall = (out_valid === 1'b1) && !out_ready;
      prevObs   = obs;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got != 100 || sent != 100 || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_count: sent=%0d got=%0d pending=%0d want 100/100/0", sent, got, q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    res_t exp;
    int   lat;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_prefill: out_valid=%b want 0", out_valid);
    end
    rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || obs !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after_edge: out_valid=%b obs=%h in_ready=%b want 0/0/1", out_valid, obs, in_ready);
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || obs !== '0) begin
        errors++;
        $display("FAIL midrst_flushed cyc%0d: out_valid=%b obs=%h want 0/0", i, out_valid, obs);
      end
    end
    in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h0BADF00D;
    exp = model(a, b);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4 || obs !== exp) begin
      errors++;
      $display("FAIL midrst_next_op: latency=%0d obs=%h want 4/%h", lat, obs, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
